// File: rtl/sensor_pkg.sv
// sensor_pkg: shared frame constants, flag bit positions, state encoding and frame length.
package sensor_pkg;
  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam int FLAG_VALID = 0;
  localparam int FLAG_OVERRUN = 1;
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  function automatic int frame_len(input int n, input int w);
    return 3 + n * (2 * w + 1);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus rise/fall detector for an asynchronous pin.
module sync_edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= !rst_n ? {3{INIT}} : {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_sensor_streamer.sv
// spi_sensor_streamer: latches sensor samples and streams them as a checksummed SPI mode-0 frame.
module spi_sensor_streamer
  import sensor_pkg::*;
#(
  parameter int N_SENSORS = 2,
  parameter int WORDS_PER_SENSOR = 7,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N_SENSORS-1:0] sample_valid,
  input  logic [N_SENSORS*WORDS_PER_SENSOR*16-1:0] sample_data,
  input  logic sck,
  input  logic cs_n,
  input  logic sdi,
  output logic sdo,
  input  logic load,
  output logic done,
  output logic frame_done,
  output logic frame_abort
);
  localparam int N = N_SENSORS;
  localparam int W = WORDS_PER_SENSOR;
  localparam int L = frame_len(N, W);
  localparam int FB = L * 8;
  localparam int CW = $clog2(FB + 1);
  state_t state, state_d;
  logic sck_q, sck_rise, sck_fall, cs_q, cs_rise, cs_fall, load_q, load_rise, load_fall;
  logic snap, adv, fin, abort, armed;
  logic [1:0] settle;
  logic [N*W*16-1:0] hold;
  logic [N-1:0] valid, ovr;
  logic [7:0] seq, sum, flags;
  logic [15:0] word;
  logic [FB-1:0] frame, sh;
  logic [CW-1:0] cnt;
  logic unused;
  sync_edge_det #(.INIT(1'b0)) u_sck (.clk(clk), .rst_n(rst_n), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  sync_edge_det #(.INIT(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  sync_edge_det #(.INIT(1'b0)) u_load (.clk(clk), .rst_n(rst_n), .d(load), .q(load_q), .rise(load_rise), .fall(load_fall));
  assign unused = &{1'b0, sdi, sck_q, sck_rise, load_q, load_fall};
  always_comb begin
    frame = '0;
    word = '0;
    flags = '0;
    sum = seq;
    frame[FB-1 -: 8] = HEADER;
    frame[FB-9 -: 8] = seq;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < W; j++) begin
        word = hold[(i*W+j)*16 +: 16];
        frame[FB-17-(i*(2*W+1)+2*j)*8 -: 16] = word;
        sum = sum + word[15:8] + word[7:0];
      end
      flags = '0;
      flags[FLAG_VALID] = valid[i];
      flags[FLAG_OVERRUN] = ovr[i];
      frame[FB-17-(i*(2*W+1)+2*W)*8 -: 8] = flags;
      sum = sum + flags;
    end
    frame[7:0] = sum;
  end
  always_comb begin
    state_d = state;
    snap = 1'b0;
    adv = 1'b0;
    fin = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: begin
        snap = cs_fall && armed;
        state_d = snap ? SHIFT : IDLE;
      end
      SHIFT: begin
        abort = cs_rise;
        adv = sck_fall && !cs_rise;
        state_d = cs_rise ? IDLE : (adv && cnt == CW'(FB - 1)) ? TAIL : SHIFT;
      end
      TAIL: begin
        fin = cs_rise;
        state_d = cs_rise ? IDLE : TAIL;
      end
      default: state_d = IDLE;
    endcase
  end
  // armed blocks a frame from starting when reset releases with cs_n already low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      seq <= '0;
      valid <= '0;
      ovr <= '0;
      hold <= '0;
      sh <= '0;
      cnt <= '0;
      sdo <= 1'b0;
      done <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      settle <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_d;
      frame_done <= fin;
      frame_abort <= abort;
      settle <= settle + {1'b0, settle != 2'd3};
      armed <= armed | (settle == 2'd3 && cs_q);
      sdo <= snap ? frame[FB-1] : adv ? sh[FB-1] : sdo & (state_d == SHIFT);
      sh <= snap ? frame << 1 : adv ? sh << 1 : sh;
      cnt <= snap ? '0 : adv ? cnt + CW'(1) : cnt;
      seq <= seq + {7'b0, fin};
      valid <= snap ? sample_valid : valid | sample_valid;
      ovr <= snap ? '0 : ovr | (valid & sample_valid);
      done <= state == IDLE ? !snap && !load_rise && (done || |sample_valid) : cs_rise && |(valid | sample_valid);
      for (int i = 0; i < N; i++)
        if (sample_valid[i]) hold[i*W*16 +: W*16] <= sample_data[i*W*16 +: W*16];
    end
  end
endmodule

// File: tb/tb_spi_sensor_streamer.sv
// tb_spi_sensor_streamer: random and directed frames on default and 4x3 instances against a byte-level model.
module tb_spi_sensor_streamer;
  logic clk = 0, rst_n = 0, sck = 0, cs_n = 1, sdi = 0, load = 0;
  logic [1:0] sv0 = '0;
  logic [223:0] sd0 = '0;
  logic [3:0] sv1 = '0;
  logic [191:0] sd1 = '0;
  logic sdo0, done0, fd0, fa0, sdo1, done1, fd1, fa1;
  int n_chk = 0, n_pass = 0;
  int unsigned hold [2][8][7];
  bit mv [2][8];
  bit mo [2][8];
  int seqm [2] = '{0, 0};
  bit mdone [2] = '{0, 0};
  int ns [2] = '{2, 4};
  int ws [2] = '{7, 3};
  byte unsigned fr [2][64];
  byte unsigned cap [2][64];
  int flen [2];
  int fdc [2] = '{0, 0};
  int fac [2] = '{0, 0};
  int efd [2] = '{0, 0};
  int efa [2] = '{0, 0};
  logic exp_sdo [2] = '{0, 0};
  logic cmp_en = 0;
  int pre;

  spi_sensor_streamer dut0 (.clk(clk), .rst_n(rst_n), .sample_valid(sv0), .sample_data(sd0), .sck(sck), .cs_n(cs_n),
    .sdi(sdi), .sdo(sdo0), .load(load), .done(done0), .frame_done(fd0), .frame_abort(fa0));
  spi_sensor_streamer #(.N_SENSORS(4), .WORDS_PER_SENSOR(3)) dut1 (.clk(clk), .rst_n(rst_n), .sample_valid(sv1),
    .sample_data(sd1), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo1), .load(load), .done(done1),
    .frame_done(fd1), .frame_abort(fa1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (fd0 === 1'b1) fdc[0]++;
    if (fd1 === 1'b1) fdc[1]++;
    if (fa0 === 1'b1) fac[0]++;
    if (fa1 === 1'b1) fac[1]++;
  end

  always @(negedge clk) if (cmp_en) begin
    check("sdo0", sdo0, exp_sdo[0]);
    check("sdo1", sdo1, exp_sdo[1]);
    check("done0", done0, mdone[0]);
    check("done1", done1, mdone[1]);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet(input int n);
    exp_sdo = '{0, 0};
    cmp_en = 1;
    tick(n);
    cmp_en = 0;
  endtask

  function automatic void build(input int d);
    int p, sum;
    fr[d][0] = 8'hAA;
    fr[d][1] = 8'(seqm[d]);
    p = 2;
    for (int c = 0; c < ns[d]; c++) begin
      for (int j = 0; j < ws[d]; j++) begin
        fr[d][p] = 8'(hold[d][c][j] >> 8);
        fr[d][p+1] = 8'(hold[d][c][j]);
        p += 2;
      end
      fr[d][p] = 8'(2 * int'(mo[d][c]) + int'(mv[d][c]));
      p++;
    end
    sum = 0;
    for (int b = 1; b < p; b++) sum += fr[d][b];
    fr[d][p] = 8'(sum);
    flen[d] = p + 1;
  endfunction

  task automatic sample(input int d, input int c, input bit fixed);
    logic [15:0] w;
    for (int j = 0; j < ws[d]; j++) begin
      w = fixed ? 16'(16'h1111 * (j + 1)) : 16'($urandom);
      hold[d][c][j] = w;
      if (d == 0) sd0[(c*7+j)*16 +: 16] = w;
      else sd1[(c*3+j)*16 +: 16] = w;
    end
    mo[d][c] = mo[d][c] | mv[d][c];
    mv[d][c] = 1;
    mdone[d] = 1;
    if (d == 0) sv0[c] = 1'b1;
    else sv1[c] = 1'b1;
    tick(1);
    sv0 = '0;
    sv1 = '0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      seqm[d] = 0;
      mdone[d] = 0;
      for (int c = 0; c < 8; c++) begin
        mv[d][c] = 0;
        mo[d][c] = 0;
        for (int j = 0; j < 7; j++) hold[d][c][j] = 0;
      end
    end
  endtask

  task automatic read(input int nbits, input int rst_at);
    bit alive;
    alive = 1;
    build(0);
    build(1);
    for (int d = 0; d < 2; d++) begin
      mdone[d] = 0;
      for (int c = 0; c < 8; c++) begin
        mv[d][c] = 0;
        mo[d][c] = 0;
      end
      for (int b = 0; b < 64; b++) cap[d][b] = 0;
    end
    cs_n = 0;
    tick(3);
    for (int k = 0; k < nbits; k++) begin
      for (int d = 0; d < 2; d++)
        exp_sdo[d] = (alive && k < flen[d] * 8) ? fr[d][k/8][7-k%8] : 1'b0;
      cmp_en = 1;
      tick(1);
      cmp_en = 0;
      cap[0][k/8][7-k%8] = sdo0;
      cap[1][k/8][7-k%8] = sdo1;
      if (k == rst_at) begin
        rst_n = 0;
        tick(1);
        rst_n = 1;
        alive = 0;
        model_reset();
      end
      sck = 1;
      tick(4);
      sck = 0;
      tick(3);
    end
    cs_n = 1;
    tick(5);
    for (int d = 0; d < 2; d++) begin
      if (alive && nbits >= flen[d] * 8) begin
        seqm[d] = (seqm[d] + 1) % 256;
        efd[d]++;
      end else if (alive) efa[d]++;
      mdone[d] = 0;
      for (int c = 0; c < 8; c++) if (mv[d][c]) mdone[d] = 1;
    end
    check("frame_done0 count", fdc[0], efd[0]);
    check("frame_done1 count", fdc[1], efd[1]);
    check("frame_abort0 count", fac[0], efa[0]);
    check("frame_abort1 count", fac[1], efa[1]);
  endtask

  initial begin
    model_reset();
    tick(3);
    check("reset sdo0", sdo0, 0);
    check("reset done0", done0, 0);
    check("reset frame_done0", fd0, 0);
    check("reset frame_abort0", fa0, 0);
    check("reset sdo1", sdo1, 0);
    check("reset done1", done1, 0);
    rst_n = 1;
    tick(6);
    quiet(4);
    sample(0, 0, 1);
    quiet(4);
    read(264, -1);
    check("header", cap[0][0], 8'hAA);
    check("seq first", cap[0][1], 8'h00);
    check("w0 msb", cap[0][2], 8'h11);
    check("w0 lsb", cap[0][3], 8'h11);
    check("w6 lsb", cap[0][15], 8'h77);
    check("flags0", cap[0][16], 8'h01);
    check("flags1", cap[0][31], 8'h00);
    check("checksum", cap[0][32], 8'hB9);
    check("checksum 4x3", cap[1][30], 8'h00);
    sample(0, 1, 0);
    tick(3);
    sample(0, 1, 0);
    quiet(4);
    read(264, -1);
    check("seq second", cap[0][1], 8'h01);
    check("flags1 overrun", cap[0][31], 8'h03);
    read(264, -1);
    check("flags1 cleared", cap[0][31], 8'h00);
    check("flags0 cleared", cap[0][16], 8'h00);
    sample(0, 0, 1);
    quiet(4);
    load = 1;
    mdone = '{0, 0};
    tick(5);
    quiet(4);
    load = 0;
    tick(4);
    quiet(2);
    load = 1;
    tick(2);
    sample(0, 1, 0);
    mdone[0] = 0;
    tick(4);
    quiet(4);
    load = 0;
    tick(4);
    read(264, -1);
    check("flags0 after load", cap[0][16], 8'h01);
    check("flags1 with load", cap[0][31], 8'h01);
    sample(0, 0, 0);
    quiet(2);
    read(40, -1);
    quiet(8);
    check("abort pulses", fac[0], 1);
    check("done pulses", fdc[0], 4);
    sample(0, 0, 0);
    quiet(2);
    read(100, 20);
    quiet(4);
    check("no abort on reset", fac[0], 1);
    read(264, -1);
    check("seq after reset", cap[0][1], 8'h00);
    pre = fdc[1];
    for (int f = 0; f < 256; f++) begin
      repeat ($urandom_range(0, 3)) begin
        int d;
        d = int'($urandom_range(0, 1));
        sample(d, int'($urandom_range(0, ns[d] - 1)), 0);
      end
      quiet(2);
      read(248, -1);
    end
    check("wrap frames", fdc[1] - pre, 256);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
